// File: rtl/pipe_adder_pkg.sv
// Shared helpers for the pipelined adder: chunk sizing, configuration check
// and the half-adder primitive the ripple chunks are built from.
package adder_pkg;

    function automatic int chunk_w(input int width, input int stages);
        return width / stages;
    endfunction

    function automatic bit chunk_ok(input int width, input int stages);
        return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

    // Returns {carry, sum}
    function automatic logic [1:0] half_add(input logic x, input logic y);
        return {x & y, x ^ y};
    endfunction

endpackage

// File: rtl/pipe_adder_if.sv
// Streaming valid/ready bus for the pipelined adder: operands in, result out.
interface pipe_adder_if #(parameter int WIDTH = 16) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
endinterface

// File: rtl/pipe_adder_chunk_adder.sv
// Combinational CHUNK-bit ripple adder made of gate-level full adders.
// msb_cin is the carry into the top bit, used for signed overflow.
module chunk_adder
    import adder_pkg::*;
#(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             msb_cin
);

    logic       carry_s;
    logic [1:0] h1_s;
    logic [1:0] h2_s;

    // Ripple chain: each bit is two half adders with their carries ORed
    always_comb begin
        carry_s = cin;
        msb_cin = cin;
        sum     = '0;
        h1_s    = 2'b00;
        h2_s    = 2'b00;
        for (int i = 0; i < CHUNK; i++) begin
            msb_cin = carry_s;
            h1_s    = half_add(a[i], b[i]);
            h2_s    = half_add(h1_s[0], carry_s);
            sum[i]  = h2_s[0];
            carry_s = h1_s[1] | h2_s[1];
        end
        cout = carry_s;
    end

endmodule

// File: rtl/pipe_adder.sv
// Pipelined WIDTH-bit adder: one CHUNK-bit slice resolved per stage, with
// elastic valid/ready stages so bubbles collapse and stalls back up cleanly.
module pipe_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input logic         clk,
    input logic         rst,
    pipe_adder_if.slave bus
);

    localparam int CHUNK = chunk_w(WIDTH, STAGES);

    if (!chunk_ok(WIDTH, STAGES)) begin : bad_cfg
        $error("pipe_adder: STAGES must divide WIDTH and lie in 1..WIDTH");
    end

    logic [STAGES-1:0] v_s;
    logic [STAGES-1:0] adv_s;
    logic              ready_s;

    // Stage k may load when empty or when everything downstream can move
    always_comb begin
        ready_s = bus.out_ready;
        adv_s   = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            ready_s  = !v_s[k] || ready_s;
            adv_s[k] = ready_s;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : stage
        localparam int REM = WIDTH - k * CHUNK;   // operand bits not yet added
        localparam int LO  = (k + 1) * CHUNK;     // sum bits resolved after this stage

        logic [REM-1:0]   src_a_s;
        logic [REM-1:0]   src_b_s;
        logic             src_c_s;
        logic             src_v_s;
        logic [CHUNK-1:0] part_s;
        logic             carry_s;
        logic             msb_cin_s;
        logic [LO-1:0]    sum_nxt_s;
        logic             v_r;
        logic [LO-1:0]    sum_r;
        logic             c_r;

        if (k == 0) begin : src_in
            assign src_a_s   = bus.a;
            assign src_b_s   = bus.b;
            assign src_c_s   = bus.cin;
            assign src_v_s   = bus.in_valid;
            assign sum_nxt_s = part_s;
        end else begin : src_prev
            assign src_a_s   = stage[k-1].fwd.a_r;
            assign src_b_s   = stage[k-1].fwd.b_r;
            assign src_c_s   = stage[k-1].c_r;
            assign src_v_s   = stage[k-1].v_r;
            assign sum_nxt_s = {part_s, stage[k-1].sum_r};
        end

        chunk_adder #(.CHUNK(CHUNK)) u_chunk (
            .a       (src_a_s[CHUNK-1:0]),
            .b       (src_b_s[CHUNK-1:0]),
            .cin     (src_c_s),
            .sum     (part_s),
            .cout    (carry_s),
            .msb_cin (msb_cin_s)
        );

        assign v_s[k] = v_r;

        // Result bits and carry; cleared when a bubble moves in so an empty
        // final stage always presents zeros
        always_ff @(posedge clk) begin
            if (rst) begin
                v_r   <= 1'b0;
                sum_r <= '0;
                c_r   <= 1'b0;
            end else if (adv_s[k]) begin
                v_r <= src_v_s;
                if (src_v_s) begin
                    sum_r <= sum_nxt_s;
                    c_r   <= carry_s;
                end else begin
                    sum_r <= '0;
                    c_r   <= 1'b0;
                end
            end
        end

        if (k < STAGES - 1) begin : fwd
            logic [REM-CHUNK-1:0] a_r;
            logic [REM-CHUNK-1:0] b_r;

            // Upper operand slices still waiting for their stage
            always_ff @(posedge clk) begin
                if (rst) begin
                    a_r <= '0;
                    b_r <= '0;
                end else if (adv_s[k] && src_v_s) begin
                    a_r <= src_a_s[REM-1:CHUNK];
                    b_r <= src_b_s[REM-1:CHUNK];
                end
            end
        end

        if (k == STAGES - 1) begin : last
            logic ovf_r;

            // Signed overflow: carry into the MSB disagrees with carry out
            always_ff @(posedge clk) begin
                if (rst) begin
                    ovf_r <= 1'b0;
                end else if (adv_s[k]) begin
                    ovf_r <= src_v_s ? (carry_s ^ msb_cin_s) : 1'b0;
                end
            end
        end else begin : mid
            logic unused_msb_s;
            assign unused_msb_s = msb_cin_s;
        end
    end

    assign bus.in_ready  = adv_s[0];
    assign bus.out_valid = stage[STAGES-1].v_r;
    assign bus.sum       = stage[STAGES-1].sum_r;
    assign bus.cout      = stage[STAGES-1].c_r;
    assign bus.ovf       = stage[STAGES-1].last.ovf_r;

endmodule

// File: tb/tb_pipe_adder.sv
// Self-checking bench for pipe_adder: directed corners on the 4-stage build,
// randomized streaming against an arithmetic model on 4, 1 and 16 stages.
module tb_pipe_adder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipe_adder_if #(.WIDTH(16)) if4 ();
    pipe_adder_if #(.WIDTH(16)) if1 ();
    pipe_adder_if #(.WIDTH(16)) if16 ();

    pipe_adder #(.WIDTH(16), .STAGES(4))  u_dut4  (.clk(clk), .rst(rst), .bus(if4));
    pipe_adder #(.WIDTH(16), .STAGES(1))  u_dut1  (.clk(clk), .rst(rst), .bus(if1));
    pipe_adder #(.WIDTH(16), .STAGES(16)) u_dut16 (.clk(clk), .rst(rst), .bus(if16));

    int passes = 0;
    int total  = 0;

    // Reference: {ovf, cout, sum} from plain integer addition
    function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y, input logic c);
        logic [16:0] full;
        logic [15:0] s;
        logic        v;
        full = 17'(x) + 17'(y) + 17'(c);
        s    = full[15:0];
        v    = (x[15] == y[15]) && (s[15] != x[15]);
        return {v, full[16], s};
    endfunction

    task automatic drive(input logic v, input logic [15:0] x, input logic [15:0] y,
                         input logic c, input logic ordy);
        if4.in_valid  = v;  if4.a  = x; if4.b  = y; if4.cin  = c; if4.out_ready  = ordy;
        if1.in_valid  = v;  if1.a  = x; if1.b  = y; if1.cin  = c; if1.out_ready  = ordy;
        if16.in_valid = v;  if16.a = x; if16.b = y; if16.cin = c; if16.out_ready = ordy;
    endtask

    task automatic test_reset();
        logic [15:0] x;
        int seen;
        drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        total++;
        if ({if4.out_valid, if4.sum, if4.cout, if4.ovf, if4.in_ready} !== {1'b0, 16'h0000, 1'b0, 1'b0, 1'b1}) begin
            $display("FAIL reset_state: got ov=%b sum=%h cout=%b ovf=%b ir=%b, want 0 0000 0 0 1",
                     if4.out_valid, if4.sum, if4.cout, if4.ovf, if4.in_ready);
        end else passes++;
        @(posedge clk); #1;
        // three items in flight, then reset while inputs keep arriving
        for (int i = 0; i < 3; i++) begin
            x = 16'($urandom);
            drive(1'b1, x, 16'($urandom), 1'b1, 1'b0);
            @(posedge clk); #1;
        end
        rst = 1'b1;
        drive(1'b1, 16'h1234, 16'h4321, 1'b1, 1'b1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
        @(negedge clk);
        total++;
        if ({if4.out_valid, if4.sum, if4.cout, if4.ovf, if4.in_ready} !== {1'b0, 16'h0000, 1'b0, 1'b0, 1'b1}) begin
            $display("FAIL reset_midstream: got ov=%b sum=%h cout=%b ovf=%b ir=%b, want 0 0000 0 0 1",
                     if4.out_valid, if4.sum, if4.cout, if4.ovf, if4.in_ready);
        end else passes++;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (if4.out_valid || if1.out_valid || if16.out_valid) seen++;
        end
        total++;
        if (seen !== 0) $display("FAIL reset_no_stale: got %0d stale results, want 0", seen);
        else passes++;
        @(posedge clk); #1;
    endtask

    task automatic test_latency();
        int lat;
        logic [17:0] got;
        lat = 0;
        got = 18'h3FFFF;
        drive(1'b1, 16'h00FF, 16'h0001, 1'b0, 1'b1);
        @(posedge clk); #1;
        drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (if4.out_valid && lat == 0) begin
                lat = c;
                got = {if4.ovf, if4.cout, if4.sum};
            end
        end
        total++;
        if (lat !== 4) $display("FAIL latency: got %0d cycles, want 4", lat);
        else passes++;
        total++;
        if (got !== {1'b0, 1'b0, 16'h0100}) $display("FAIL latency_value: got %h, want %h", got, {2'b00, 16'h0100});
        else passes++;
        @(posedge clk); #1;
    endtask

    task automatic test_corners();
        logic [15:0] ta [3] = '{16'hFFFF, 16'h7FFF, 16'h8000};
        logic [15:0] tb [3] = '{16'h0000, 16'h0001, 16'h8000};
        logic        tc [3] = '{1'b1, 1'b0, 1'b0};
        logic [17:0] te [3] = '{{1'b0, 1'b1, 16'h0000}, {1'b1, 1'b0, 16'h8000}, {1'b1, 1'b1, 16'h0000}};
        logic [17:0] got;
        bit seen;
        for (int t = 0; t < 3; t++) begin
            seen = 1'b0;
            got  = 18'h3FFFF;
            drive(1'b1, ta[t], tb[t], tc[t], 1'b1);
            @(posedge clk); #1;
            drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                if (if4.out_valid && !seen) begin
                    seen = 1'b1;
                    got  = {if4.ovf, if4.cout, if4.sum};
                end
            end
            total++;
            if (!seen || got !== te[t])
                $display("FAIL corner_%0d: got seen=%b {ovf,cout,sum}=%h, want %h", t, seen, got, te[t]);
            else passes++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        logic [17:0] got_q [$];
        int          cyc_q [$];
        logic [15:0] x;
        int bad_ir;
        bad_ir = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (cyc < 8) begin
                x = 16'(cyc) * 16'h1111;
                drive(1'b1, x, 16'h0101, 1'(cyc & 1), 1'b1);
            end else begin
                drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
            end
            @(negedge clk);
            if (cyc < 8 && if4.in_ready !== 1'b1) bad_ir++;
            if (if4.out_valid) begin
                got_q.push_back({if4.ovf, if4.cout, if4.sum});
                cyc_q.push_back(cyc);
            end
            @(posedge clk); #1;
        end
        total++;
        if (bad_ir !== 0) $display("FAIL b2b_in_ready: got %0d low cycles, want 0", bad_ir);
        else passes++;
        total++;
        if (got_q.size() !== 8) $display("FAIL b2b_count: got %0d results, want 8", got_q.size());
        else passes++;
        for (int i = 0; i < got_q.size() && i < 8; i++) begin
            x = 16'(i) * 16'h1111;
            total++;
            if (got_q[i] !== model(x, 16'h0101, 1'(i & 1)) || cyc_q[i] !== cyc_q[0] + i)
                $display("FAIL b2b_item_%0d: got %h at cycle %0d, want %h at cycle %0d",
                         i, got_q[i], cyc_q[i], model(x, 16'h0101, 1'(i & 1)), cyc_q[0] + i);
            else passes++;
        end
    endtask

    task automatic test_backpressure();
        logic [17:0] exp_q [$];
        logic [17:0] held, cur, want;
        logic [15:0] x, y;
        logic c, last_ir;
        bit have;
        int acc, got;
        acc = 0; got = 0; have = 1'b0; held = '0; last_ir = 1'b1;
        for (int cyc = 0; cyc < 9; cyc++) begin
            x = 16'($urandom); y = 16'($urandom); c = 1'($urandom_range(1, 0));
            drive(1'b1, x, y, c, 1'b0);
            @(negedge clk);
            last_ir = if4.in_ready;
            if (if4.in_ready) begin
                exp_q.push_back(model(x, y, c));
                acc++;
            end
            if (if4.out_valid) begin
                cur = {if4.ovf, if4.cout, if4.sum};
                if (!have) begin
                    held = cur;
                    have = 1'b1;
                end else begin
                    total++;
                    if (cur !== held) $display("FAIL bp_stable_%0d: got %h, want %h", cyc, cur, held);
                    else passes++;
                end
            end
            @(posedge clk); #1;
        end
        total++;
        if (acc !== 4 || last_ir !== 1'b0)
            $display("FAIL bp_fill: got accepted=%0d in_ready=%b, want 4 and 0", acc, last_ir);
        else passes++;
        drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            if (if4.out_valid) begin
                cur = {if4.ovf, if4.cout, if4.sum};
                total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL bp_extra: got %h, want no further result", cur);
                end else begin
                    want = exp_q.pop_front();
                    if (cur !== want) $display("FAIL bp_drain_%0d: got %h, want %h", got, cur, want);
                    else passes++;
                end
                got++;
            end
            @(posedge clk); #1;
        end
        total++;
        if (got !== acc) $display("FAIL bp_count: got %0d out, want %0d", got, acc);
        else passes++;
    endtask

    task automatic test_random();
        logic [17:0] exp_q [3][$];
        int          n_in  [3];
        int          n_out [3];
        logic        ir    [3];
        logic        ov    [3];
        logic [17:0] res   [3];
        logic [17:0] want;
        logic [15:0] x, y;
        logic c, v, ordy;
        int bad;
        bad = 0;
        for (int j = 0; j < 3; j++) begin n_in[j] = 0; n_out[j] = 0; end
        drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int cyc = 0; cyc < 4100; cyc++) begin
            x = 16'($urandom); y = 16'($urandom); c = 1'($urandom_range(1, 0));
            v    = (cyc < 4000) ? 1'($urandom_range(1, 0)) : 1'b0;
            ordy = (cyc < 4000) ? 1'($urandom_range(1, 0)) : 1'b1;
            drive(v, x, y, c, ordy);
            @(negedge clk);
            ir[0] = if4.in_ready;  ov[0] = if4.out_valid;  res[0] = {if4.ovf, if4.cout, if4.sum};
            ir[1] = if1.in_ready;  ov[1] = if1.out_valid;  res[1] = {if1.ovf, if1.cout, if1.sum};
            ir[2] = if16.in_ready; ov[2] = if16.out_valid; res[2] = {if16.ovf, if16.cout, if16.sum};
            for (int j = 0; j < 3; j++) begin
                if (v && ir[j]) begin
                    exp_q[j].push_back(model(x, y, c));
                    n_in[j]++;
                end
                if (ov[j] && ordy) begin
                    n_out[j]++;
                    total++;
                    if (exp_q[j].size() == 0) begin
                        $display("FAIL rand_extra_%0d: got %h, want none", j, res[j]);
                    end else begin
                        want = exp_q[j].pop_front();
                        if (res[j] !== want) begin
                            if (bad < 10)
                                $display("FAIL rand_item_%0d: got %h, want %h (cycle %0d)", j, res[j], want, cyc);
                            bad++;
                        end else passes++;
                    end
                end
            end
            @(posedge clk); #1;
        end
        for (int j = 0; j < 3; j++) begin
            total++;
            if (n_out[j] !== n_in[j] || n_in[j] < 500)
                $display("FAIL rand_count_%0d: got in=%0d out=%0d, want equal and >= 500", j, n_in[j], n_out[j]);
            else passes++;
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_corners();
        test_back_to_back();
        test_backpressure();
        test_random();
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
